// File: rtl/stage_exe_md.sv
// stage_exe_md: execute stage with forwarding, ALU, iterative multiply/divide and HI/LO.
// Divider exists only when STAGE_EXE_MD_DIV_EN is defined; otherwise DIV/DIVU retire as bubbles.
module stage_exe_md #(
  parameter int XLEN = 32,
  parameter int CW   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic [XLEN-1:0] data_imm,
  input  logic [3:0]      control_oper,
  input  logic            control_use_b,
  input  logic            control_reg_dst,
  input  logic [2:0]      control_md,
  input  logic [1:0]      for_a,
  input  logic [1:0]      for_b,
  input  logic [XLEN-1:0] result_from_exe,
  input  logic [XLEN-1:0] result_from_mem,
  input  logic [4:0]      regaddr1,
  input  logic [4:0]      regaddr2,
  input  logic [CW-1:0]   ctrl_in,
  input  logic            nop_id,
  input  logic            flush,
  input  logic            stall,
  output logic [XLEN-1:0] out,
  output logic [XLEN-1:0] data_b_o,
  output logic [4:0]      regaddr_o,
  output logic [4:0]      rt_id,
  output logic [CW-1:0]   ctrl_o,
  output logic            nop,
  output logic            md_busy
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res;
  logic [3:0]      op_eff;
  logic [SHW-1:0]  sh;
  logic            md_mul, md_div, md_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept, start_mul, start_div;

  logic [XLEN:0]   acc_hi;
  logic [XLEN-1:0] acc_lo, opnd, hi, lo;
  logic [CNTW-1:0] cnt;
  logic            neg_lo;

  logic [XLEN:0]     mul_sum, mul_hi_nx;
  logic [XLEN-1:0]   mul_lo_nx;
  logic [2*XLEN-1:0] prod_mag, prod;

  // Operand forwarding
  always_comb begin
    case (for_a)
      2'b01:   op_a = result_from_exe;
      2'b10:   op_a = result_from_mem;
      default: op_a = data_a;
    endcase
    case (for_b)
      2'b01:   op_b = result_from_exe;
      2'b10:   op_b = result_from_mem;
      default: op_b = data_b;
    endcase
  end

  assign alu_b = control_use_b ? data_imm : op_b;
  assign sh    = alu_b[SHW-1:0];

  // control_oper 0 selects an R-type op from funct; unknown functs produce 0.
  always_comb begin
    op_eff = control_oper;
    if (control_oper == 4'd0) begin
      case (data_imm[5:0])
        6'h20, 6'h21: op_eff = 4'd1;
        6'h22, 6'h23: op_eff = 4'd2;
        6'h24:        op_eff = 4'd3;
        6'h25:        op_eff = 4'd4;
        6'h26:        op_eff = 4'd5;
        6'h27:        op_eff = 4'd6;
        6'h2a:        op_eff = 4'd7;
        6'h2b:        op_eff = 4'd8;
        default:      op_eff = 4'd0;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_eff)
      4'd1:  alu_res = op_a + alu_b;
      4'd2:  alu_res = op_a - alu_b;
      4'd3:  alu_res = op_a & alu_b;
      4'd4:  alu_res = op_a | alu_b;
      4'd5:  alu_res = op_a ^ alu_b;
      4'd6:  alu_res = ~(op_a | alu_b);
      4'd7:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
      4'd8:  alu_res = {{(XLEN-1){1'b0}}, op_a < alu_b};
      4'd9:  alu_res = alu_b << (XLEN / 2);
      4'd10: alu_res = op_a << sh;
      4'd11: alu_res = op_a >> sh;
      4'd12: alu_res = $unsigned($signed(op_a) >>> sh);
      4'd13, 4'd14, 4'd15: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  assign md_mul = (control_md == 3'd1) || (control_md == 3'd2);
  assign md_div = (control_md == 3'd3) || (control_md == 3'd4);
  assign md_sgn = (control_md == 3'd1) || (control_md == 3'd3);
  assign a_neg  = md_sgn & op_a[XLEN-1];
  assign b_neg  = md_sgn & op_b[XLEN-1];
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;

  assign accept    = (state == IDLE) & ~flush & ~stall;
  assign start_mul = accept & md_mul & ~nop_id;
`ifdef STAGE_EXE_MD_DIV_EN
  assign start_div = accept & md_div & ~nop_id;
`else
  assign start_div = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_mul)      state_nx = MUL;
        else if (start_div) state_nx = DIV;
      end
      MUL, DIV: if (cnt == CNTW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign md_busy = (state != IDLE);

  // Shift-add: {acc_hi, acc_lo} starts as {0, multiplier} and shifts right each step.
  assign mul_sum   = acc_lo[0] ? acc_hi + {1'b0, opnd} : acc_hi;
  assign mul_hi_nx = {1'b0, mul_sum[XLEN:1]};
  assign mul_lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
  assign prod_mag  = {mul_hi_nx[XLEN-1:0], mul_lo_nx};
  assign prod      = neg_lo ? -prod_mag : prod_mag;

`ifdef STAGE_EXE_MD_DIV_EN
  logic            neg_hi, ge;
  logic [XLEN:0]   rem_sh, div_hi_nx;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] div_lo_nx, quo, rem;

  // Restoring division: dividend bits shift out of acc_lo into the partial remainder.
  assign rem_sh    = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
  assign diff      = {1'b0, rem_sh} - {2'b00, opnd};
  assign ge        = ~diff[XLEN+1];
  assign div_hi_nx = ge ? diff[XLEN:0] : rem_sh;
  assign div_lo_nx = {acc_lo[XLEN-2:0], ge};
  assign quo       = neg_lo ? -div_lo_nx : div_lo_nx;
  assign rem       = neg_hi ? -div_hi_nx[XLEN-1:0] : div_hi_nx[XLEN-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef STAGE_EXE_MD_DIV_EN
      neg_hi <= 1'b0;
`endif
    end else if (start_mul) begin
      acc_hi <= '0;
      acc_lo <= b_mag;
      opnd   <= a_mag;
      cnt    <= CNTW'(XLEN);
      neg_lo <= a_neg ^ b_neg;
`ifdef STAGE_EXE_MD_DIV_EN
    end else if (start_div) begin
      acc_hi <= '0;
      acc_lo <= a_mag;
      opnd   <= b_mag;
      cnt    <= CNTW'(XLEN);
      // A zero divisor naturally yields all-ones quotient and remainder = |dividend|;
      // suppressing quotient negation keeps LO all ones and HI equal to the dividend.
      neg_lo <= (a_neg ^ b_neg) & (|op_b);
      neg_hi <= a_neg;
    end else if (state == DIV) begin
      acc_hi <= div_hi_nx;
      acc_lo <= div_lo_nx;
      cnt    <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) begin
        hi <= rem;
        lo <= quo;
      end
`endif
    end else if (state == MUL) begin
      acc_hi <= mul_hi_nx;
      acc_lo <= mul_lo_nx;
      cnt    <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) begin
        hi <= prod[2*XLEN-1:XLEN];
        lo <= prod[XLEN-1:0];
      end
    end
  end

  // MD-issuing instructions, busy cycles, flush and stall all leave as bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      data_b_o  <= '0;
      regaddr_o <= '0;
      rt_id     <= '0;
      ctrl_o    <= '0;
      nop       <= 1'b1;
    end else if (!accept || md_mul || md_div) begin
      out       <= '0;
      data_b_o  <= '0;
      regaddr_o <= '0;
      rt_id     <= '0;
      ctrl_o    <= '0;
      nop       <= 1'b1;
    end else begin
      out       <= (control_md == 3'd5) ? hi : (control_md == 3'd6) ? lo : alu_res;
      data_b_o  <= op_b;
      regaddr_o <= control_reg_dst ? regaddr1 : regaddr2;
      rt_id     <= regaddr2;
      ctrl_o    <= ctrl_in;
      nop       <= nop_id;
    end
  end

endmodule

// File: tb/tb_stage_exe_md.sv
// Bench for stage_exe_md: vector table, directed MD sequences and random stimulus vs. a reference model.
module tb_stage_exe_md;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] data_a, data_b, data_imm, result_from_exe, result_from_mem;
  logic [3:0]  control_oper;
  logic        control_use_b, control_reg_dst, nop_id, flush, stall;
  logic [2:0]  control_md, ctrl_in;
  logic [1:0]  for_a, for_b;
  logic [4:0]  regaddr1, regaddr2;
  logic [31:0] out, data_b_o;
  logic [4:0]  regaddr_o, rt_id;
  logic [2:0]  ctrl_o;
  logic        nop, md_busy;

  logic [15:0] a16, b16, out16, db16;
  logic [2:0]  md16, ctrl16;
  logic [4:0]  ra16, rt16;
  logic        nop16, busy16;

  stage_exe_md #(.XLEN(32), .CW(3)) dut (
    .clock(clock), .reset(reset), .data_a(data_a), .data_b(data_b), .data_imm(data_imm),
    .control_oper(control_oper), .control_use_b(control_use_b), .control_reg_dst(control_reg_dst),
    .control_md(control_md), .for_a(for_a), .for_b(for_b), .result_from_exe(result_from_exe),
    .result_from_mem(result_from_mem), .regaddr1(regaddr1), .regaddr2(regaddr2), .ctrl_in(ctrl_in),
    .nop_id(nop_id), .flush(flush), .stall(stall), .out(out), .data_b_o(data_b_o),
    .regaddr_o(regaddr_o), .rt_id(rt_id), .ctrl_o(ctrl_o), .nop(nop), .md_busy(md_busy)
  );

  stage_exe_md #(.XLEN(16), .CW(3)) dut16 (
    .clock(clock), .reset(reset), .data_a(a16), .data_b(b16), .data_imm(16'h0000),
    .control_oper(4'd0), .control_use_b(1'b0), .control_reg_dst(1'b0),
    .control_md(md16), .for_a(2'b00), .for_b(2'b00), .result_from_exe(16'h0000),
    .result_from_mem(16'h0000), .regaddr1(5'd0), .regaddr2(5'd0), .ctrl_in(3'd0),
    .nop_id(1'b0), .flush(1'b0), .stall(1'b0), .out(out16), .data_b_o(db16),
    .regaddr_o(ra16), .rt_id(rt16), .ctrl_o(ctrl16), .nop(nop16), .md_busy(busy16)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mhi = '0, mlo = '0;

  typedef struct {
    logic [3:0]  oper;
    logic        use_b;
    logic        reg_dst;
    logic [1:0]  fa, fb;
    logic [31:0] a, b, imm, rexe, rmem, exp_out, exp_b;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [3:0] o;
    int unsigned s;
    o = op;
    if (op == 4'd0) begin
      case (fn)
        6'h20, 6'h21: o = 4'd1;
        6'h22, 6'h23: o = 4'd2;
        6'h24: o = 4'd3;
        6'h25: o = 4'd4;
        6'h26: o = 4'd5;
        6'h27: o = 4'd6;
        6'h2a: o = 4'd7;
        6'h2b: o = 4'd8;
        default: return 32'd0;
      endcase
    end
    s = b % 32;
    case (o)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return ~(a | b);
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return {b[15:0], 16'h0000};
      4'd10: return a << s;
      4'd11: return a >> s;
      4'd12: return 32'(int'(a) >>> s);
      default: return b;
    endcase
  endfunction

  task automatic md_ref(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (md)
      3'd1: begin p = 64'(sa * sb); {mhi, mlo} = p; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; end
`ifdef STAGE_EXE_MD_DIV_EN
      3'd3: if (b == 0) begin mlo = '1; mhi = a; end
            else begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      3'd4: if (b == 0) begin mlo = '1; mhi = a; end
            else begin mlo = a / b; mhi = a % b; end
`endif
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    data_a = 0; data_b = 0; data_imm = 0; result_from_exe = 0; result_from_mem = 0;
    control_oper = 4'd1; control_use_b = 0; control_reg_dst = 1; control_md = 0;
    for_a = 0; for_b = 0; regaddr1 = 5'd7; regaddr2 = 5'd9; ctrl_in = 3'b101;
    nop_id = 0; flush = 0; stall = 0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    control_md = 3'd5; flush = 0; stall = 0; nop_id = 0;
    tick(); hi = out;
    control_md = 3'd6;
    tick(); lo = out;
    control_md = 3'd0;
  endtask

  // Issue an MD op, hold MFLO upstream while busy, then MFLO and MFHI.
  task automatic run_md(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] rlo, output logic [31:0] rhi,
                        output logic bub_ok);
    control_md = md; data_a = a; data_b = b; for_a = 0; for_b = 0; nop_id = 0;
    flush = 0; stall = 0; ctrl_in = 3'b101; control_reg_dst = 1;
    tick();
    bub_ok = (nop === 1'b1) && (ctrl_o === 3'd0) && (regaddr_o === 5'd0);
    control_md = 3'd6;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 200) begin
      if (nop !== 1'b1 || ctrl_o !== 3'd0 || regaddr_o !== 5'd0) bub_ok = 1'b0;
      tick();
      cyc++;
    end
    tick(); rlo = out;
    control_md = 3'd5;
    tick(); rhi = out;
    control_md = 3'd0;
  endtask

  initial begin
    vec_t tab[12];
    logic [5:0] fn_tab[11];
    int cyc;
    logic [31:0] rlo, rhi;
    logic bok;

    tab[0]  = '{4'd1,  1'b0, 1'b1, 2'b01, 2'b00, 32'd5, 32'd7, 32'd0, 32'd100, 32'd0, 32'd107, 32'd7};
    tab[1]  = '{4'd2,  1'b1, 1'b0, 2'b00, 2'b00, 32'd10, 32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd11, 32'd3};
    tab[2]  = '{4'd0,  1'b0, 1'b1, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'd0, 32'd0, 32'd1, 32'd1};
    tab[3]  = '{4'd0,  1'b0, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h2B, 32'd0, 32'd0, 32'd0, 32'd1};
    tab[4]  = '{4'd3,  1'b0, 1'b1, 2'b00, 2'b10, 32'hF0F0F0F0, 32'd0, 32'd0, 32'd0, 32'hFF00FF00, 32'hF000F000, 32'hFF00FF00};
    tab[5]  = '{4'd1,  1'b0, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    tab[6]  = '{4'd1,  1'b0, 1'b1, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'd1};
    tab[7]  = '{4'd9,  1'b1, 1'b0, 2'b00, 2'b00, 32'd0, 32'd5, 32'h1234, 32'd0, 32'd0, 32'h12340000, 32'd5};
    tab[8]  = '{4'd12, 1'b0, 1'b1, 2'b00, 2'b00, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'd0, 32'hF8000000, 32'd4};
    tab[9]  = '{4'd10, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1, 32'd31, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'd31};
    tab[10] = '{4'd0,  1'b0, 1'b1, 2'b00, 2'b00, 32'd1, 32'd2, 32'h3F, 32'd0, 32'd0, 32'd0, 32'd2};
    tab[11] = '{4'd1,  1'b0, 1'b0, 2'b11, 2'b01, 32'd3, 32'd4, 32'd0, 32'd99, 32'd88, 32'd102, 32'd99};
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

    reset = 1'b0;
    idle_inputs();
    a16 = 0; b16 = 0; md16 = 0;
    tick(); tick();
    chk("reset_out", out, 0);
    chk("reset_nop", nop, 1);
    chk("reset_busy", md_busy, 0);
    chk("reset_side", {data_b_o, regaddr_o, rt_id, ctrl_o}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      control_oper = tab[i].oper; control_use_b = tab[i].use_b; control_reg_dst = tab[i].reg_dst;
      for_a = tab[i].fa; for_b = tab[i].fb; data_a = tab[i].a; data_b = tab[i].b;
      data_imm = tab[i].imm; result_from_exe = tab[i].rexe; result_from_mem = tab[i].rmem;
      regaddr1 = 5'd3; regaddr2 = 5'd9; ctrl_in = 3'b110; nop_id = 0; control_md = 0;
      tick();
      chk($sformatf("vec%0d_out", i), out, tab[i].exp_out);
      chk($sformatf("vec%0d_side", i), {data_b_o, regaddr_o, rt_id, ctrl_o, nop},
          {tab[i].exp_b, (tab[i].reg_dst ? 5'd3 : 5'd9), 5'd9, 3'b110, 1'b0});
    end
    idle_inputs();

    // MULT -3 * 7
    run_md(3'd1, 32'hFFFFFFFD, 32'd7, cyc, rlo, rhi, bok);
    md_ref(3'd1, 32'hFFFFFFFD, 32'd7);
    chk("mult_busy_cycles", cyc, 32);
    chk("mult_bubbles", bok, 1);
    chk("mult_lo", rlo, 32'hFFFFFFEB);
    chk("mult_hi", rhi, 32'hFFFFFFFF);

`ifdef STAGE_EXE_MD_DIV_EN
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, cyc, rlo, rhi, bok);
    md_ref(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_busy_cycles", cyc, 32);
    chk("div_lo", rlo, 32'hFFFFFFFD);
    chk("div_hi", rhi, 32'hFFFFFFFF);
    run_md(3'd4, 32'd9, 32'd0, cyc, rlo, rhi, bok);
    md_ref(3'd4, 32'd9, 32'd0);
    chk("divu0_lo", rlo, 32'hFFFFFFFF);
    chk("divu0_hi", rhi, 32'd9);
`else
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, cyc, rlo, rhi, bok);
    chk("div_off_busy", cyc, 0);
    chk("div_off_bubble", bok, 1);
    chk("div_off_lo", rlo, 32'hFFFFFFEB);
    chk("div_off_hi", rhi, 32'hFFFFFFFF);
`endif

    // MULTU issued under flush must not start
    control_md = 3'd2; data_a = 32'd6; data_b = 32'd7; flush = 1;
    tick();
    chk("flush_issue_busy", md_busy, 0);
    chk("flush_issue_nop", nop, 1);
    flush = 0;
    read_hilo(rhi, rlo);
    chk("flush_issue_hilo", {rhi, rlo}, {mhi, mlo});

    // flush on busy cycle 10 does not disturb the op
    control_md = 3'd2; data_a = 32'd6; data_b = 32'd7;
    tick();
    control_md = 3'd0;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 200) begin
      flush = (cyc == 10);
      tick();
      cyc++;
    end
    flush = 0;
    md_ref(3'd2, 32'd6, 32'd7);
    chk("flush_busy_cycles", cyc, 32);
    read_hilo(rhi, rlo);
    chk("flush_busy_hilo", {rhi, rlo}, {32'd0, 32'd42});

    // stall bubbles a normal instruction
    control_oper = 4'd1; data_a = 32'd20; data_b = 32'd22; stall = 1;
    tick();
    chk("stall_bubble", {out, ctrl_o, regaddr_o, nop}, {32'd0, 3'd0, 5'd0, 1'b1});
    stall = 0;
    tick();
    chk("stall_release", out, 32'd42);

    // random ALU / MFHI / MFLO traffic
    for (int i = 0; i < 150; i++) begin
      logic [2:0] mdsel;
      logic [31:0] fa_v, fb_v, bv, exp;
      data_a = $urandom; data_b = $urandom; data_imm = $urandom;
      result_from_exe = $urandom; result_from_mem = $urandom;
      control_oper = 4'($urandom_range(0, 15));
      if (control_oper == 0) data_imm[5:0] = fn_tab[$urandom_range(0, 10)];
      control_use_b = 1'($urandom); control_reg_dst = 1'($urandom);
      for_a = 2'($urandom); for_b = 2'($urandom);
      regaddr1 = 5'($urandom); regaddr2 = 5'($urandom); ctrl_in = 3'($urandom);
      nop_id = 1'($urandom);
      case ($urandom_range(0, 5))
        0: mdsel = 3'd5;
        1: mdsel = 3'd6;
        2: mdsel = 3'd7;
        default: mdsel = 3'd0;
      endcase
      control_md = mdsel;
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 9) == 0);
      fa_v = (for_a == 1) ? result_from_exe : (for_a == 2) ? result_from_mem : data_a;
      fb_v = (for_b == 1) ? result_from_exe : (for_b == 2) ? result_from_mem : data_b;
      bv = control_use_b ? data_imm : fb_v;
      exp = (mdsel == 5) ? mhi : (mdsel == 6) ? mlo : alu_ref(control_oper, data_imm[5:0], fa_v, bv);
      tick();
      if (flush || stall) begin
        chk($sformatf("rnd%0d_bubble", i), {out, data_b_o, regaddr_o, rt_id, ctrl_o, nop},
            {32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 1'b1});
      end else begin
        chk($sformatf("rnd%0d_out", i), out, exp);
        chk($sformatf("rnd%0d_side", i), {data_b_o, regaddr_o, rt_id, ctrl_o, nop},
            {fb_v, (control_reg_dst ? regaddr1 : regaddr2), regaddr2, ctrl_in, nop_id});
      end
    end
    idle_inputs();

    // random MD ops
    for (int i = 0; i < 12; i++) begin
      logic [2:0] md;
      logic [31:0] a, b;
      md = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : (i % 4 == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      run_md(md, a, b, cyc, rlo, rhi, bok);
      md_ref(md, a, b);
`ifdef STAGE_EXE_MD_DIV_EN
      chk($sformatf("rmd%0d_cycles", i), cyc, 32);
`else
      chk($sformatf("rmd%0d_cycles", i), cyc, (md <= 3'd2) ? 32 : 0);
`endif
      chk($sformatf("rmd%0d_bubbles", i), bok, 1);
      chk($sformatf("rmd%0d_hilo", i), {rhi, rlo}, {mhi, mlo});
    end

    // reset mid-multiply
    control_md = 3'd1; data_a = 32'd3; data_b = 32'd5;
    tick();
    control_md = 3'd0;
    repeat (15) tick();
    chk("pre_reset_busy", md_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_busy", md_busy, 0);
    chk("async_reset_nop", nop, 1);
    chk("async_reset_out", out, 0);
    mhi = '0; mlo = '0;
    tick();
    reset = 1'b1;
    repeat (40) tick();
    read_hilo(rhi, rlo);
    chk("post_reset_hilo", {rhi, rlo}, 64'd0);

    // 16-bit instance MULTU 0xFFFF * 0xFFFF
    md16 = 3'd2; a16 = 16'hFFFF; b16 = 16'hFFFF;
    tick();
    md16 = 3'd0;
    cyc = 0;
    while (busy16 === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("x16_busy_cycles", cyc, 16);
    md16 = 3'd6;
    tick();
    chk("x16_lo", out16, 16'h0001);
    md16 = 3'd5;
    tick();
    chk("x16_hi", out16, 16'hFFFE);
    md16 = 3'd0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
